gravity_lock_timer: RTL and testbench

//  Parametrised successor to the gravity down-tick generator. Emits one-cycle down_signal

---
 rtl/tetris_timing_pkg.sv | 32 +++
 rtl/tick_counter.sv | 28 ++
 rtl/gravity_lock_timer.sv | 142 ++++++++++++++
 tb/tb_gravity_lock_timer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_timing_pkg.sv
// Shared timing definitions for the gravity / lock-delay timer: FSM states,
// default timing constants and the saturating gravity-period function.
package tetris_timing_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FALL,
        LOCK
    } state_t;

    localparam int DEF_CNT_W           = 26;
    localparam int DEF_LEVEL_W         = 4;
    localparam int DEF_MAX_COUNT       = 51_000_000;
    localparam int DEF_STEP            = 2_900_000;
    localparam int DEF_MIN_PERIOD      = 1_000_000;
    localparam int DEF_SOFT_PERIOD     = 5_000_000;
    localparam int DEF_LOCK_COUNT      = 25_000_000;
    localparam int DEF_MAX_LOCK_RESETS = 15;

    // Signed arithmetic so a level beyond the last step goes negative and floors cleanly.
    function automatic longint gravity_period(
        input longint level,
        input longint max_count,
        input longint step,
        input longint min_period
    );
        longint g;
        g = max_count - step * level;
        return (g < min_period) ? min_period : g;
    endfunction

endpackage

// File: rtl/tick_counter.sv
// Loadable down-counter: a load stores load_val-1, then the count walks toward
// zero on every cycle en is high and parks at zero until the next load.
module tick_counter #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val - CNT_W'(1);
        end else if (en && count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/gravity_lock_timer.sv
// Gravity down-tick generator with soft-drop auto-repeat and a lock-delay timer
// whose restarts are limited by a per-piece move-reset budget.
module gravity_lock_timer
    import tetris_timing_pkg::*;
#(
    parameter int CNT_W           = DEF_CNT_W,
    parameter int LEVEL_W         = DEF_LEVEL_W,
    parameter int MAX_COUNT       = DEF_MAX_COUNT,
    parameter int STEP            = DEF_STEP,
    parameter int MIN_PERIOD      = DEF_MIN_PERIOD,
    parameter int SOFT_PERIOD     = DEF_SOFT_PERIOD,
    parameter int LOCK_COUNT      = DEF_LOCK_COUNT,
    parameter int MAX_LOCK_RESETS = DEF_MAX_LOCK_RESETS
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     enable,
    input  logic [LEVEL_W-1:0]                       level,
    input  logic                                     new_piece,
    input  logic                                     soft_drop,
    input  logic                                     hard_drop,
    input  logic                                     grounded,
    input  logic                                     moved,
    output logic                                     down_signal,
    output logic                                     lock_signal,
    output logic [$clog2(MAX_LOCK_RESETS+1)-1:0]     lock_resets_left
);

    localparam int RW = $clog2(MAX_LOCK_RESETS + 1);

    state_t           state;
    state_t           state_nxt;
    logic [RW-1:0]    budget_nxt;
    logic             down_nxt;
    logic             lock_nxt;
    logic             soft_prev;
    logic             soft_rise;
    logic             soft_fall;
    logic             fall_load;
    logic [CNT_W-1:0] fall_val;
    logic             fall_zero;
    logic             lock_load;
    logic             lock_zero;
    logic [CNT_W-1:0] grav_period;
    logic [CNT_W-1:0] soft_period;

    assign grav_period = CNT_W'(gravity_period(longint'(level), longint'(MAX_COUNT),
                                               longint'(STEP), longint'(MIN_PERIOD)));
    assign soft_period = (grav_period < CNT_W'(SOFT_PERIOD)) ? grav_period : CNT_W'(SOFT_PERIOD);
    assign soft_rise   = soft_drop && !soft_prev;
    assign soft_fall   = !soft_drop && soft_prev;

    tick_counter #(.CNT_W(CNT_W)) u_fall_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (fall_load),
        .load_val (fall_val),
        .en       (enable && state == FALL),
        .zero     (fall_zero)
    );

    tick_counter #(.CNT_W(CNT_W)) u_lock_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lock_load),
        .load_val (CNT_W'(LOCK_COUNT)),
        .en       (enable && state == LOCK),
        .zero     (lock_zero)
    );

    // Everything is gated by enable so a paused game freezes counters and state alike.
    always_comb begin
        state_nxt  = state;
        budget_nxt = lock_resets_left;
        down_nxt   = 1'b0;
        lock_nxt   = 1'b0;
        fall_load  = 1'b0;
        fall_val   = grav_period;
        lock_load  = 1'b0;
        if (enable) begin
            if (new_piece) begin
                state_nxt  = FALL;
                fall_load  = 1'b1;
                budget_nxt = RW'(MAX_LOCK_RESETS);
            end else if (hard_drop && state != IDLE) begin
                lock_nxt  = 1'b1;
                state_nxt = IDLE;
            end else begin
                case (state)
                    FALL: begin
                        if (grounded) begin
                            state_nxt = LOCK;
                            lock_load = 1'b1;
                        end else if (soft_rise) begin
                            down_nxt  = 1'b1;
                            fall_load = 1'b1;
                            fall_val  = soft_period;
                        end else if (fall_zero) begin
                            down_nxt  = 1'b1;
                            fall_load = 1'b1;
                            fall_val  = soft_drop ? soft_period : grav_period;
                        end else if (soft_fall) begin
                            fall_load = 1'b1;
                        end
                    end
                    LOCK: begin
                        if (!grounded) begin
                            state_nxt = FALL;
                            fall_load = 1'b1;
                        end else if (moved && lock_resets_left != '0) begin
                            lock_load  = 1'b1;
                            budget_nxt = lock_resets_left - RW'(1);
                        end else if (lock_zero) begin
                            lock_nxt  = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            lock_resets_left <= '0;
            down_signal      <= 1'b0;
            lock_signal      <= 1'b0;
            soft_prev        <= 1'b0;
        end else begin
            state            <= state_nxt;
            lock_resets_left <= budget_nxt;
            down_signal      <= down_nxt;
            lock_signal      <= lock_nxt;
            if (enable) begin
                soft_prev <= soft_drop;
            end
        end
    end

endmodule

// File: tb/tb_gravity_lock_timer.sv
// Bench for gravity_lock_timer: vector table, timed corner-case sequences and a
// randomized run against a deadline-based reference model.
`timescale 1ns/1ps
module tb_gravity_lock_timer;

    localparam int CNT_W   = 26;
    localparam int LEVEL_W = 4;
    localparam int MAXC    = 100;
    localparam int STEPC   = 10;
    localparam int MINP    = 4;
    localparam int SOFTP   = 3;
    localparam int LOCKC   = 20;
    localparam int MAXR    = 2;
    localparam int RW      = $clog2(MAXR + 1);

    localparam int M_IDLE = 0;
    localparam int M_FALL = 1;
    localparam int M_LOCK = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               enable = 1'b0;
    logic [LEVEL_W-1:0] level = '0;
    logic               new_piece = 1'b0;
    logic               soft_drop = 1'b0;
    logic               hard_drop = 1'b0;
    logic               grounded = 1'b0;
    logic               moved = 1'b0;
    logic               down_signal;
    logic               lock_signal;
    logic [RW-1:0]      lock_resets_left;

    int checks = 0;
    int errors = 0;

    // Reference model: deadlines measured in enabled cycles
    int m_mode;
    int m_due;
    int m_budget;
    int m_ecnt;
    bit m_soft_prev;
    bit e_down;
    bit e_lock;

    typedef struct {
        bit en;
        int lvl;
        bit np;
        bit sd;
        bit hd;
        bit gd;
        bit mv;
        bit d;
        bit l;
        int b;
    } vec_t;

    vec_t tbl[19];

    always #5 clk = ~clk;

    gravity_lock_timer #(
        .CNT_W           (CNT_W),
        .LEVEL_W         (LEVEL_W),
        .MAX_COUNT       (MAXC),
        .STEP            (STEPC),
        .MIN_PERIOD      (MINP),
        .SOFT_PERIOD     (SOFTP),
        .LOCK_COUNT      (LOCKC),
        .MAX_LOCK_RESETS (MAXR)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .level            (level),
        .new_piece        (new_piece),
        .soft_drop        (soft_drop),
        .hard_drop        (hard_drop),
        .grounded         (grounded),
        .moved            (moved),
        .down_signal      (down_signal),
        .lock_signal      (lock_signal),
        .lock_resets_left (lock_resets_left)
    );

    function automatic int g_period(input int lv);
        int g;
        g = MAXC - STEPC * lv;
        return (g < MINP) ? MINP : g;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_due = 0;
        m_budget = 0;
        m_ecnt = 0;
        m_soft_prev = 1'b0;
        e_down = 1'b0;
        e_lock = 1'b0;
    endtask

    task automatic model_step();
        int g;
        int s;
        int e;
        bit rise;
        bit fall_e;
        e_down = 1'b0;
        e_lock = 1'b0;
        if (!enable) return;
        e = m_ecnt;
        g = g_period(int'(level));
        s = (g < SOFTP) ? g : SOFTP;
        rise = soft_drop && !m_soft_prev;
        fall_e = !soft_drop && m_soft_prev;
        if (new_piece) begin
            m_mode = M_FALL;
            m_due = e + g;
            m_budget = MAXR;
        end else if (hard_drop && m_mode != M_IDLE) begin
            e_lock = 1'b1;
            m_mode = M_IDLE;
        end else if (m_mode == M_FALL) begin
            if (grounded) begin
                m_mode = M_LOCK;
                m_due = e + LOCKC;
            end else if (rise) begin
                e_down = 1'b1;
                m_due = e + s;
            end else if (e == m_due) begin
                e_down = 1'b1;
                m_due = e + (soft_drop ? s : g);
            end else if (fall_e) begin
                m_due = e + g;
            end
        end else if (m_mode == M_LOCK) begin
            if (!grounded) begin
                m_mode = M_FALL;
                m_due = e + g;
            end else if (moved && m_budget > 0) begin
                m_due = e + LOCKC;
                m_budget--;
            end else if (e == m_due) begin
                e_lock = 1'b1;
                m_mode = M_IDLE;
            end
        end
        m_soft_prev = soft_drop;
        m_ecnt++;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check("down", int'(down_signal), int'(e_down));
        check("lock", int'(lock_signal), int'(e_lock));
        check("budget", int'(lock_resets_left), m_budget);
    endtask

    task automatic clear_inputs();
        new_piece = 1'b0;
        soft_drop = 1'b0;
        hard_drop = 1'b0;
        grounded = 1'b0;
        moved = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_down", int'(down_signal), 0);
        check("rst_lock", int'(lock_signal), 0);
        check("rst_budget", int'(lock_resets_left), 0);
        rst_n = 1'b1;
        model_reset();
        enable = 1'b1;
    endtask

    task automatic wait_pulse(input bit want_lock, input int max_cycles, output int n, output int others);
        n = -1;
        others = 0;
        for (int i = 1; i <= max_cycles; i++) begin
            step();
            if (want_lock ? lock_signal : down_signal) begin
                n = i;
                break;
            end
            if (want_lock ? down_signal : lock_signal) others++;
        end
    endtask

    task automatic start_piece(input int lv);
        level = LEVEL_W'(lv);
        new_piece = 1'b1;
        step();
        new_piece = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int o;
        int cnt;

        //            en lvl np sd hd gd mv  d  l  b
        tbl[0]  = '{1, 15, 1, 0, 0, 0, 0, 0, 0, 2};
        tbl[1]  = '{1, 15, 0, 0, 0, 0, 0, 0, 0, 2};
        tbl[2]  = '{1, 15, 0, 0, 0, 0, 0, 0, 0, 2};
        tbl[3]  = '{1, 15, 0, 0, 0, 0, 0, 0, 0, 2};
        tbl[4]  = '{1, 15, 0, 0, 0, 0, 0, 1, 0, 2};
        tbl[5]  = '{1, 15, 0, 0, 0, 1, 0, 0, 0, 2};
        tbl[6]  = '{1, 15, 0, 0, 0, 1, 1, 0, 0, 1};
        tbl[7]  = '{1, 15, 0, 0, 0, 1, 1, 0, 0, 0};
        tbl[8]  = '{1, 15, 0, 0, 0, 1, 1, 0, 0, 0};
        tbl[9]  = '{1, 15, 0, 0, 1, 1, 0, 0, 1, 0};
        tbl[10] = '{1, 15, 0, 0, 1, 0, 0, 0, 0, 0};
        tbl[11] = '{0, 15, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[12] = '{1, 15, 1, 0, 0, 0, 0, 0, 0, 2};
        tbl[13] = '{1, 15, 0, 1, 0, 0, 0, 1, 0, 2};
        tbl[14] = '{0, 15, 0, 1, 0, 0, 0, 0, 0, 2};
        tbl[15] = '{1, 15, 0, 1, 0, 0, 0, 0, 0, 2};
        tbl[16] = '{1, 15, 0, 1, 0, 0, 0, 0, 0, 2};
        tbl[17] = '{1, 15, 0, 1, 0, 0, 0, 1, 0, 2};
        tbl[18] = '{1, 15, 0, 0, 0, 1, 0, 0, 0, 2};

        do_reset();
        for (int i = 0; i < 19; i++) begin
            enable    = tbl[i].en;
            level     = LEVEL_W'(tbl[i].lvl);
            new_piece = tbl[i].np;
            soft_drop = tbl[i].sd;
            hard_drop = tbl[i].hd;
            grounded  = tbl[i].gd;
            moved     = tbl[i].mv;
            model_step();
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_down", i), int'(down_signal), int'(tbl[i].d));
            check($sformatf("vec%0d_lock", i), int'(lock_signal), int'(tbl[i].l));
            check($sformatf("vec%0d_budget", i), int'(lock_resets_left), tbl[i].b);
        end

        // Level 0 gravity: pulses every 100 cycles
        do_reset();
        start_piece(0);
        wait_pulse(1'b0, 150, n, o);
        check("lvl0_first", n, 100);
        wait_pulse(1'b0, 150, n, o);
        check("lvl0_second", n, 100);

        // Level 15 saturates to the minimum period
        start_piece(15);
        wait_pulse(1'b0, 20, n, o);
        check("lvl15_first", n, 4);
        wait_pulse(1'b0, 20, n, o);
        check("lvl15_second", n, 4);

        // Soft drop: immediate pulse, repeat every 3, release returns to gravity
        start_piece(0);
        repeat (9) step();
        soft_drop = 1'b1;
        step();
        check("soft_rise_pulse", int'(down_signal), 1);
        wait_pulse(1'b0, 10, n, o);
        check("soft_repeat1", n, 3);
        wait_pulse(1'b0, 10, n, o);
        check("soft_repeat2", n, 3);
        soft_drop = 1'b0;
        step();
        wait_pulse(1'b0, 150, n, o);
        check("soft_release", n, 100);

        // Grounded on the expiry cycle: lock wins, no down pulse
        start_piece(15);
        repeat (3) step();
        grounded = 1'b1;
        step();
        check("ground_at_expiry", int'(down_signal), 0);
        wait_pulse(1'b1, 40, n, o);
        check("lock_delay", n, 20);
        check("lock_no_down", o, 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            cnt += int'(down_signal) + int'(lock_signal);
        end
        check("idle_quiet", cnt, 0);

        // Move-reset budget: two reloads, third move ignored
        grounded = 1'b0;
        start_piece(15);
        grounded = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            repeat (4) step();
            moved = 1'b1;
            step();
            moved = 1'b0;
            check($sformatf("budget_after_move%0d", k + 1), int'(lock_resets_left), (k < 2) ? 1 - k : 0);
        end
        wait_pulse(1'b1, 40, n, o);
        check("lock_after_moves", n + 5, 20);

        // Move on the lock-expiry cycle reloads instead of locking
        grounded = 1'b0;
        start_piece(15);
        grounded = 1'b1;
        step();
        repeat (19) step();
        moved = 1'b1;
        step();
        moved = 1'b0;
        check("move_beats_expiry", int'(lock_signal), 0);
        check("move_beats_expiry_budget", int'(lock_resets_left), 1);
        wait_pulse(1'b1, 40, n, o);
        check("lock_after_late_move", n, 20);

        // Pause for 50 cycles delays the next pulse by exactly 50
        grounded = 1'b0;
        start_piece(0);
        repeat (30) step();
        enable = 1'b0;
        repeat (50) step();
        enable = 1'b1;
        wait_pulse(1'b0, 200, n, o);
        check("pause_delay", 30 + 50 + n, 150);

        // Asynchronous reset mid-LOCK
        start_piece(15);
        grounded = 1'b1;
        repeat (4) step();
        check("pre_reset_budget", int'(lock_resets_left), 2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_budget", int'(lock_resets_left), 0);
        check("async_rst_down", int'(down_signal), 0);
        check("async_rst_lock", int'(lock_signal), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            moved = (i % 5 == 0);
            step();
            cnt += int'(down_signal) + int'(lock_signal);
        end
        moved = 1'b0;
        check("post_reset_quiet", cnt, 0);

        // Randomized run against the reference model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            enable    = ($urandom_range(0, 9) != 0);
            level     = ($urandom_range(0, 3) == 0) ? LEVEL_W'($urandom_range(0, 15))
                                                    : LEVEL_W'($urandom_range(8, 15));
            new_piece = ($urandom_range(0, 60) == 0);
            hard_drop = ($urandom_range(0, 150) == 0);
            moved     = ($urandom_range(0, 8) == 0);
            if ($urandom_range(0, 15) == 0) soft_drop = ~soft_drop;
            if ($urandom_range(0, 25) == 0) grounded = ~grounded;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
